fetch_unit: RTL

//  Instruction fetch stage for one core of the multi-core design. It sits directly upstream of
//  ins_mem. It owns the program counter and drives the memory address and read-enable. It

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_pc_counter.sv | 39 +++
 rtl/fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the halt opcode.
// The decoder imports the same opcode so both ends agree on what stops a core.
package fetch_unit_pkg;

  // 3-bit binary state encoding; codes 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StCapture = 3'd2,
    StPresent = 3'd3,
    StHalt    = 3'd4
  } fetch_state_e;

  localparam int unsigned DefInsWidth  = 9;
  localparam int unsigned DefAddrWidth = 8;

  // Instruction word that stops fetching; it never reaches the decoder via ir_out.
  localparam logic [DefInsWidth-1:0] HaltOpcode = 9'h1FF;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: async reset, load of an absolute address, modulo increment.
module pc_counter
  import fetch_unit_pkg::*;
#(
  parameter int unsigned            WIDTH   = DefAddrWidth,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_d, pc_q;

  // Load wins over increment; increment wraps silently at 2**WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RST_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives ins_mem, captures the registered
// instruction word into the IR and presents it to the decoder over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned                ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned                INS_WIDTH   = DefInsWidth,
  parameter logic [ADDR_WIDTH-1:0]      START_ADDR  = '0,
  parameter logic [INS_WIDTH-1:0]       HALT_OPCODE = INS_WIDTH'(HaltOpcode)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  mem_rEn,
  input  logic [INS_WIDTH-1:0]  mem_ins,
  output logic [INS_WIDTH-1:0]  ir_out,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  halted
);

  fetch_state_e state_q, state_d;

  logic [INS_WIDTH-1:0]  ir_out_q, ir_out_d;
  logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;

  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_val;
  logic                  pc_inc;
  logic [ADDR_WIDTH-1:0] pc;

  pc_counter #(
    .WIDTH   (ADDR_WIDTH),
    .RST_VAL (START_ADDR)
  ) u_pc_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // Next-state, IR capture and PC control.
  always_comb begin
    state_d     = state_q;
    ir_out_d    = ir_out_q;
    ir_pc_d     = ir_pc_q;
    pc_load     = 1'b0;
    pc_load_val = START_ADDR;
    pc_inc      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          pc_load = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        if (mem_ins == HALT_OPCODE) begin
          state_d = StHalt;
        end else begin
          ir_out_d = mem_ins;
          ir_pc_d  = pc;
          state_d  = StPresent;
        end
      end
      StPresent: begin
        // ir_valid is high throughout PRESENT, so ir_ready alone completes the handshake.
        if (ir_ready) begin
          if (jump_en) begin
            pc_load     = 1'b1;
            pc_load_val = jump_addr;
          end else begin
            pc_inc = 1'b1;
          end
          state_d = StIssue;
        end
      end
      StHalt: begin
        if (start) begin
          pc_load = 1'b1;
          state_d = StIssue;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and instruction register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ir_out_q <= '0;
      ir_pc_q  <= '0;
    end else begin
      state_q  <= state_d;
      ir_out_q <= ir_out_d;
      ir_pc_q  <= ir_pc_d;
    end
  end

  // Outputs decoded from registered state, so they are glitch-free and reset-clean.
  always_comb begin
    pc_addr  = pc;
    mem_rEn  = (state_q == StIssue);
    ir_valid = (state_q == StPresent);
    halted   = (state_q == StHalt);
    ir_out   = ir_out_q;
    ir_pc    = ir_pc_q;
  end

endmodule
